encode42_buf: RTL and testbench

ENCODE42_BUF -- requirements
Module: encode42_buf

---
 rtl/encode42_buf.sv | 109 ++++++++++
 tb/tb_encode42_buf.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/encode42_buf.sv
// Priority 4:2 encoder feeding a 2-entry FIFO of {index, zero, err} with a push counter.
// Optional macro ENCODE_ONEHOT_CHECK_EN flags multi-hot input words through err.
module encode42_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_in,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic [1:0] o_out,
    output logic       o_zero,
    output logic       o_err,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_enc_count
);

    // Highest set bit wins; an all-zero word maps to index 0.
    function automatic logic [1:0] enc_idx(input logic [3:0] v);
        logic [1:0] idx;
        if (v[3]) begin
            idx = 2'd3;
        end else if (v[2]) begin
            idx = 2'd2;
        end else if (v[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

`ifdef ENCODE_ONEHOT_CHECK_EN
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    function automatic logic multi_hot(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction
`endif

    logic [3:0] r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_occ;
    logic [7:0] r_count;

    logic       w_push;
    logic       w_pop;
    logic       w_err;
    logic       w_out_valid;
    logic [3:0] w_entry;
    logic [3:0] w_head;

`ifdef ENCODE_ONEHOT_CHECK_EN
    assign w_err = multi_hot(i_in);
`else
    assign w_err = 1'b0;
`endif

    assign w_entry     = {enc_idx(i_in), (i_in == 4'd0), w_err};
    assign o_in_ready  = (r_occ != 2'd2);
    assign w_out_valid = (r_occ != 2'd0);
    assign o_out_valid = w_out_valid;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = w_out_valid && i_out_ready;
    assign o_enc_count = r_count;

    // FIFO storage, pointers, occupancy and push counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= 4'd0;
            r_mem[1] <= 4'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
            r_count  <= 8'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= ~r_wr_ptr;
                r_count         <= r_count + 8'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Head entry presented only while the buffer holds something, zero otherwise.
    always_comb begin
        w_head = r_mem[r_rd_ptr];
        o_out  = 2'd0;
        o_zero = 1'b0;
        o_err  = 1'b0;
        if (w_out_valid) begin
            o_out  = w_head[3:2];
            o_zero = w_head[1];
            o_err  = w_head[0];
        end else begin
            o_out  = 2'd0;
            o_zero = 1'b0;
            o_err  = 1'b0;
        end
    end

endmodule

// File: tb/tb_encode42_buf.sv
// Self-checking bench for encode42_buf: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_encode42_buf;

    logic       clk;
    logic       rst_n;
    logic [3:0] i_in;
    logic       i_in_valid;
    logic       o_in_ready;
    logic [1:0] o_out;
    logic       o_zero;
    logic       o_err;
    logic       o_out_valid;
    logic       i_out_ready;
    logic [7:0] o_enc_count;

    typedef struct {
        logic [1:0] idx;
        logic       z;
        logic       e;
    } entry_t;

    entry_t mq[$];
    int     m_count;
    int     n_err;
    int     n_chk;

    encode42_buf dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in        (i_in),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_out       (o_out),
        .o_zero      (o_zero),
        .o_err       (o_err),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_enc_count (o_enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic entry_t model_entry(input logic [3:0] v);
        entry_t e;
        e.idx = 2'd0;
        for (int b = 0; b < 4; b++) begin
            if (v[b]) e.idx = 2'(b);
        end
        e.z = (v == 4'd0);
`ifdef ENCODE_ONEHOT_CHECK_EN
        e.e = ($countones(v) >= 2);
`else
        e.e = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [4:0] model_head();
        if (mq.size() == 0) return 5'b0;
        return {1'b1, mq[0].idx, mq[0].z, mq[0].e};
    endfunction

    // Called at a negedge: drive inputs, step one rising edge, update model, return at negedge.
    task automatic cycle(input logic [3:0] v, input logic vld, input logic rdy);
        bit push;
        bit pop;
        i_in        = v;
        i_in_valid  = vld;
        i_out_ready = rdy;
        @(posedge clk);
        push = vld && (mq.size() < 2);
        pop  = rdy && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(model_entry(v));
            m_count = (m_count + 1) % 256;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        m_count = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_in = 4'd0; i_in_valid = 1'b0; i_out_ready = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if ({o_in_ready, o_out_valid, o_out, o_zero, o_err, o_enc_count} !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b vld=%b out=%0d z=%b e=%b cnt=%0d expected rdy=1 vld=0 out=0 z=0 e=0 cnt=0",
                     o_in_ready, o_out_valid, o_out, o_zero, o_err, o_enc_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] words [4];
        words[0] = 4'd1; words[1] = 4'd2; words[2] = 4'd4; words[3] = 4'd8;
        for (int i = 0; i < 4; i++) begin
            cycle(words[i], 1'b1, 1'b1);
            n_chk++;
            if ({o_out_valid, o_out, o_zero, o_err} !== {1'b1, 2'(i), 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL basic_seq[%0d]: got vld=%b out=%0d z=%b e=%b expected vld=1 out=%0d z=0 e=0",
                         i, o_out_valid, o_out, o_zero, o_err, i);
            end
        end
        cycle(4'd0, 1'b0, 1'b1);
        n_chk++;
        if (o_enc_count !== 8'd4 || o_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_count: got cnt=%0d vld=%b expected cnt=4 vld=0", o_enc_count, o_out_valid);
        end
    endtask

    task automatic test_full();
        int base;
        base = m_count;
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);
        n_chk++;
        if (o_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: got in_ready=%b expected 0", o_in_ready);
        end
        cycle(4'b1000, 1'b1, 1'b0);
        n_chk++;
        if (o_enc_count !== 8'((base + 2) % 256) || o_out !== 2'd2 || o_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL full_hold: got cnt=%0d out=%0d vld=%b expected cnt=%0d out=2 vld=1",
                     o_enc_count, o_out, o_out_valid, (base + 2) % 256);
        end
        cycle(4'd0, 1'b0, 1'b1);
        n_chk++;
        if ({o_out_valid, o_out, o_zero, o_in_ready} !== {1'b1, 2'd0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL full_pop1: got vld=%b out=%0d z=%b rdy=%b expected vld=1 out=0 z=1 rdy=1",
                     o_out_valid, o_out, o_zero, o_in_ready);
        end
        cycle(4'd0, 1'b0, 1'b1);
        n_chk++;
        if (o_out_valid !== 1'b0 || o_enc_count !== 8'((base + 2) % 256)) begin
            n_err++;
            $display("FAIL full_drain: got vld=%b cnt=%0d expected vld=0 cnt=%0d", o_out_valid, o_enc_count, (base + 2) % 256);
        end
    endtask

    task automatic test_err();
        logic exp_e;
`ifdef ENCODE_ONEHOT_CHECK_EN
        exp_e = 1'b1;
`else
        exp_e = 1'b0;
`endif
        cycle(4'b0110, 1'b1, 1'b0);
        cycle(4'b1011, 1'b1, 1'b0);
        n_chk++;
        if ({o_out, o_zero, o_err} !== {2'd2, 1'b0, exp_e}) begin
            n_err++;
            $display("FAIL err_first: got out=%0d z=%b e=%b expected out=2 z=0 e=%b", o_out, o_zero, o_err, exp_e);
        end
        cycle(4'd0, 1'b0, 1'b1);
        n_chk++;
        if ({o_out, o_zero, o_err} !== {2'd3, 1'b0, exp_e}) begin
            n_err++;
            $display("FAIL err_second: got out=%0d z=%b e=%b expected out=3 z=0 e=%b", o_out, o_zero, o_err, exp_e);
        end
        cycle(4'd0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int start;
        int bad;
        start = m_count;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            cycle(4'($urandom_range(0, 15)), 1'b1, 1'b1);
            n_chk++;
            if (o_in_ready !== 1'b1 || mq.size() > 1) begin
                n_err++;
                bad++;
                if (bad < 5) $display("FAIL b2b_ready[%0d]: got in_ready=%b expected 1", i, o_in_ready);
            end
        end
        n_chk++;
        if (o_enc_count !== 8'(start)) begin
            n_err++;
            $display("FAIL b2b_wrap: got cnt=%0d expected %0d", o_enc_count, start);
        end
        cycle(4'd0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [4:0] exp_h;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            exp_h = model_head();
            n_chk++;
            if ({o_out_valid, o_out, o_zero, o_err} !== exp_h || o_in_ready !== (mq.size() < 2)
                || o_enc_count !== 8'(m_count)) begin
                n_err++;
                bad++;
                if (bad < 8)
                    $display("FAIL random[%0d]: got vld=%b out=%0d z=%b e=%b rdy=%b cnt=%0d expected vld/out/z/e=%b rdy=%b cnt=%0d",
                             i, o_out_valid, o_out, o_zero, o_err, o_in_ready, o_enc_count, exp_h, (mq.size() < 2), m_count);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(4'b0010, 1'b1, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b0001, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if ({o_out_valid, o_in_ready, o_enc_count} !== {1'b0, 1'b1, 8'd0}) begin
            n_err++;
            $display("FAIL midreset_async: got vld=%b rdy=%b cnt=%0d expected vld=0 rdy=1 cnt=0",
                     o_out_valid, o_in_ready, o_enc_count);
        end
        i_in = 4'hF; i_in_valid = 1'b1; i_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (o_out_valid !== 1'b0 || o_enc_count !== 8'd0) begin
            n_err++;
            $display("FAIL midreset_edge: got vld=%b cnt=%0d expected vld=0 cnt=0", o_out_valid, o_enc_count);
        end
        rst_n = 1'b1;
        cycle(4'b1000, 1'b1, 1'b0);
        n_chk++;
        if ({o_out_valid, o_out, o_zero, o_enc_count} !== {1'b1, 2'd3, 1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL midreset_first_push: got vld=%b out=%0d z=%b cnt=%0d expected vld=1 out=3 z=0 cnt=1",
                     o_out_valid, o_out, o_zero, o_enc_count);
        end
    endtask

    initial begin
        n_err = 0;
        n_chk = 0;
        m_count = 0;
        test_reset();
        test_basic();
        test_full();
        test_err();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
